// File: rtl/matriz_pkg.sv
// matriz_pkg: scanner FSM states and default matrix geometry shared with matriz_displayer
package matriz_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, EVAL} state_t;
  localparam int SCAN_STEPS = 5;
  localparam int SENSE_WIDTH = 7;
  localparam int MAP_WIDTH = SCAN_STEPS * SENSE_WIDTH;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/matriz_scanner.sv
// matriz_scanner: scans a switch matrix one line at a time and publishes a debounced map
module matriz_scanner #(
  parameter int SCAN_STEPS      = matriz_pkg::SCAN_STEPS,
  parameter int SENSE_WIDTH     = matriz_pkg::SENSE_WIDTH,
  parameter int MAP_WIDTH       = matriz_pkg::MAP_WIDTH,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scan_enable,
  input  logic [SENSE_WIDTH-1:0] matriz_sense_data,
  output logic [SCAN_STEPS-1:0]  matriz_scan_drive,
  output logic [MAP_WIDTH-1:0]   map,
  output logic                   frame_done,
  output logic                   map_changed
);
  import matriz_pkg::*;
  localparam int STEP_W = SCAN_STEPS > 1 ? $clog2(SCAN_STEPS) : 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES);
  localparam int STABLE_W = $clog2(DEBOUNCE_FRAMES) + 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SCAN_STEPS - 1);
  localparam logic [SETTLE_W-1:0] LAST_SETTLE = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [STABLE_W-1:0] LAST_STABLE = STABLE_W'(DEBOUNCE_FRAMES - 1);
  state_t state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [STABLE_W-1:0] stable_q, stable_d;
  logic [MAP_WIDTH-1:0] raw_q, raw_d, prev_raw_q, prev_raw_d, map_q, map_d;
  logic [SCAN_STEPS-1:0] drive_q, drive_d;
  logic [SENSE_WIDTH-1:0] sense_s;
  sync2 #(.WIDTH(SENSE_WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (matriz_sense_data),
    .q     (sense_s)
  );
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    settle_d = settle_q;
    stable_d = stable_q;
    raw_d = raw_q;
    prev_raw_d = prev_raw_q;
    map_d = map_q;
    frame_done = 1'b0;
    map_changed = 1'b0;
    if (state_q == IDLE) begin
      step_d = '0;
      settle_d = '0;
      state_d = scan_enable ? DRIVE : IDLE;
    end else if (state_q == DRIVE && !scan_enable) begin
      state_d = IDLE;
      step_d = '0;
      settle_d = '0;
      raw_d = '0;
      stable_d = '0;
    end else if (state_q == DRIVE) begin
      settle_d = settle_q == LAST_SETTLE ? '0 : settle_q + 1'b1;
      if (settle_q == LAST_SETTLE) begin
        raw_d[step_q*SENSE_WIDTH +: SENSE_WIDTH] = sense_s;
        step_d = step_q == LAST_STEP ? '0 : step_q + 1'b1;
        state_d = step_q == LAST_STEP ? EVAL : DRIVE;
      end
    end else begin
      frame_done = 1'b1;
      stable_d = raw_q != prev_raw_q ? '0 : stable_q == LAST_STABLE ? stable_q : stable_q + 1'b1;
      prev_raw_d = raw_q;
      map_changed = stable_d == LAST_STABLE && raw_q != map_q;
      map_d = map_changed ? raw_q : map_q;
      state_d = scan_enable ? DRIVE : IDLE;
    end
    drive_d = state_d == DRIVE ? SCAN_STEPS'(1) << step_d : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q <= '0;
      settle_q <= '0;
      stable_q <= '0;
      raw_q <= '0;
      prev_raw_q <= '0;
      map_q <= '0;
      drive_q <= '0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      settle_q <= settle_d;
      stable_q <= stable_d;
      raw_q <= raw_d;
      prev_raw_q <= prev_raw_d;
      map_q <= map_d;
      drive_q <= drive_d;
    end
  end
  assign matriz_scan_drive = drive_q;
  assign map = map_q;
endmodule

// File: tb/tb_matriz_scanner.sv
// tb_matriz_scanner: randomized frame-level check of matriz_scanner against a debounce model
module tb_matriz_scanner;
  localparam int STEPS = 5;
  localparam int SW = 7;
  localparam int MW = 35;
  localparam int SETTLE = 4;
  localparam int DF = 3;
  localparam int FRAME = STEPS * SETTLE + 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scan_enable = 1'b0;
  logic [SW-1:0] sense = '0;
  logic [STEPS-1:0] drive;
  logic [MW-1:0] map;
  logic frame_done, map_changed;
  int total = 0;
  int passed = 0;
  logic [MW-1:0] cur_pat = '0;
  logic [MW-1:0] m_prev = '0;
  logic [MW-1:0] m_map = '0;
  int m_stable = 0;
  always #5 clk = ~clk;
  matriz_scanner dut (
    .clk               (clk),
    .reset             (reset),
    .scan_enable       (scan_enable),
    .matriz_sense_data (sense),
    .matriz_scan_drive (drive),
    .map               (map),
    .frame_done        (frame_done),
    .map_changed       (map_changed)
  );
  task automatic tick();
    @(posedge clk);
    #1;
    sense = SW'($urandom);
    for (int k = 0; k < STEPS; k++)
      if (drive[k]) sense = cur_pat[k*SW +: SW];
  endtask
  task automatic model_reset();
    m_prev = '0;
    m_map = '0;
    m_stable = 0;
  endtask
  task automatic run_frame(input logic [MW-1:0] pat, input string tag);
    logic exp_mc;
    logic [STEPS-1:0] ed;
    logic [41:0] exp_v;
    cur_pat = pat;
    if (pat == m_prev) m_stable = m_stable < DF - 1 ? m_stable + 1 : DF - 1;
    else begin
      m_stable = 0;
      m_prev = pat;
    end
    exp_mc = m_stable == DF - 1 && pat != m_map;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      ed = c < STEPS * SETTLE ? STEPS'(1) << (c / SETTLE) : '0;
      exp_v = {ed, c == FRAME - 1, c == FRAME - 1 && exp_mc, m_map};
      total++;
      if ({drive, frame_done, map_changed, map} !== exp_v)
        $display("FAIL %s cycle %0d: {drive,fd,mc,map} got %h expected %h", tag, c, {drive, frame_done, map_changed, map}, exp_v);
      else passed++;
    end
    if (exp_mc) m_map = pat;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    scan_enable = 1'b0;
    for (int i = 0; i < 53; i++) begin
      if (i == 3) reset = 1'b0;
      tick();
      total++;
      if ({drive, frame_done, map_changed, map} !== 42'd0)
        $display("FAIL reset_idle cycle %0d: got %h expected 0", i, {drive, frame_done, map_changed, map});
      else passed++;
    end
    model_reset();
  endtask
  task automatic test_drive_sequence();
    scan_enable = 1'b1;
    run_frame('0, "drive_seq0");
    run_frame('0, "drive_seq1");
  endtask
  task automatic test_debounce();
    logic [MW-1:0] p;
    p = MW'(7'h55) << (2 * SW);
    run_frame(p, "debounce1");
    run_frame(p, "debounce2");
    total++;
    if (map !== '0) $display("FAIL debounce_early: map got %h expected 0", map);
    else passed++;
    run_frame(p, "debounce3");
    tick();
    total++;
    if (map !== 35'h0_0015_4000) $display("FAIL debounce_map: map got %h expected %h", map, 35'h0_0015_4000);
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
  endtask
  task automatic test_bounce();
    logic [MW-1:0] p;
    p = MW'(7'h55) << (2 * SW);
    for (int f = 0; f < 10; f++) run_frame(f % 2 == 0 ? p : '0, "bounce");
    total++;
    if (map !== '0) $display("FAIL bounce_map: map got %h expected 0", map);
    else passed++;
  endtask
  task automatic test_abort();
    logic [MW-1:0] q;
    logic [STEPS-1:0] ed;
    q = {MW'($urandom), 3'($urandom)} | MW'(1);
    cur_pat = q;
    for (int c = 0; c < 14; c++) begin
      tick();
      ed = STEPS'(1) << (c / SETTLE);
      total++;
      if ({drive, frame_done, map_changed} !== {ed, 2'b00})
        $display("FAIL abort_partial cycle %0d: {drive,fd,mc} got %h expected %h", c, {drive, frame_done, map_changed}, {ed, 2'b00});
      else passed++;
    end
    scan_enable = 1'b0;
    m_stable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({drive, frame_done, map_changed, map} !== {7'd0, m_map})
        $display("FAIL abort_idle cycle %0d: got %h expected %h", i, {drive, frame_done, map_changed, map}, {7'd0, m_map});
      else passed++;
    end
    scan_enable = 1'b1;
    run_frame(q, "abort_refill1");
    run_frame(q, "abort_refill2");
    run_frame(q, "abort_refill3");
  endtask
  task automatic test_reset_mid_frame();
    logic [STEPS-1:0] ed;
    cur_pat = {MW'($urandom), 3'($urandom)};
    for (int c = 0; c < 9; c++) begin
      tick();
      ed = STEPS'(1) << (c / SETTLE);
      total++;
      if ({drive, map} !== {ed, m_map})
        $display("FAIL rstmid_partial cycle %0d: {drive,map} got %h expected %h", c, {drive, map}, {ed, m_map});
      else passed++;
    end
    total++;
    if (map === '0) $display("FAIL rstmid_precond: map got %h expected nonzero", map);
    else passed++;
    reset = 1'b1;
    tick();
    total++;
    if ({drive, frame_done, map_changed, map} !== 42'd0)
      $display("FAIL rstmid_clear: got %h expected 0", {drive, frame_done, map_changed, map});
    else passed++;
    reset = 1'b0;
    model_reset();
    run_frame(cur_pat, "rstmid_resume");
  endtask
  task automatic test_random();
    logic [MW-1:0] a, b;
    a = {MW'($urandom), 3'($urandom)};
    b = {MW'($urandom), 3'($urandom)};
    for (int f = 0; f < 14; f++) run_frame($urandom_range(0, 3) == 0 ? b : a, "random");
  endtask
  initial begin
    test_reset();
    test_drive_sequence();
    test_debounce();
    test_bounce();
    test_abort();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
